// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver for DIGITS common-select digits.
// Each digit gets a slot of SCAN_DIV clocks. The first BLANK_CYC clocks of a
// slot are dead time. The remaining clocks are PWM-gated by bright.
// Per-digit data and attributes are snapshotted at frame start, so a
// display update never tears mid-frame.
module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 32768,
  parameter int BLANK_CYC    = 256,
  parameter int BLINK_FRAMES = 64,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit SEL_ACT_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     SEG_S,
  output logic [7:0]            SEG
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [7:0]        SEG_OFF = {8{SEG_ACT_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACT_LOW}};

  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_off;

  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dp, snap_blank, snap_blink;
  logic                snap_lz;

  logic slot_last, idx_last, frame_last, frame_start;

  assign slot_last   = (slot_cnt == SW'(SCAN_DIV - 1));
  assign idx_last    = (idx == IW'(DIGITS - 1));
  assign frame_last  = (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign frame_start = (slot_cnt == '0) && (idx == '0);

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0:    font = 7'h40;
      4'h1:    font = 7'h79;
      4'h2:    font = 7'h24;
      4'h3:    font = 7'h30;
      4'h4:    font = 7'h19;
      4'h5:    font = 7'h12;
      4'h6:    font = 7'h02;
      4'h7:    font = 7'h78;
      4'h8:    font = 7'h00;
      4'h9:    font = 7'h10;
      4'hA:    font = 7'h08;
      4'hB:    font = 7'h03;
      4'hC:    font = 7'h46;
      4'hD:    font = 7'h21;
      4'hE:    font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  // Slot, digit and frame counters, and the blink phase.
  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      if (idx_last) begin
        idx <= '0;
        if (frame_last) begin
          frame_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Frame-coherent snapshot of the display contents.
  // NOTE: the snapshot is reset explicitly so a fresh start shows defined data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_data  <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_blink <= '0;
      snap_lz    <= 1'b0;
    end else if (frame_start) begin
      snap_data  <= data;
      snap_dp    <= dp;
      snap_blank <= blank;
      snap_blink <= blink;
      snap_lz    <= lz_en;
    end
  end

  // At frame start the freshly sampled inputs take the place of the snapshot.
  // The snapshot is only updated at the clock edge that ends that cycle.
  logic [4*DIGITS-1:0] eff_data;
  logic [DIGITS-1:0]   eff_dp, eff_blank, eff_blink;
  logic                eff_lz;

  assign eff_data  = frame_start ? data  : snap_data;
  assign eff_dp    = frame_start ? dp    : snap_dp;
  assign eff_blank = frame_start ? blank : snap_blank;
  assign eff_blink = frame_start ? blink : snap_blink;
  assign eff_lz    = frame_start ? lz_en : snap_lz;

  logic [DIGITS-1:0] suppress, one_hot;
  logic              zero_above, cur_dp, cur_blank, cur_blink, cur_sup, lit;
  logic [3:0]        cur_nib;
  logic [7:0]        pattern, next_seg;
  logic [DIGITS-1:0] next_sel;

  // Leading-zero mask, current-digit selection, lit decision and output encoding.
  // NOTE: every signal gets a default first, so no latches are inferred.
  always_comb begin
    suppress   = '0;
    one_hot    = '0;
    zero_above = 1'b1;
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_blink  = 1'b0;
    cur_sup    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above && (eff_data[4*i +: 4] == 4'h0) && !eff_dp[i];
      suppress[i] = eff_lz && zero_above && (i != 0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        one_hot[i] = 1'b1;
        cur_nib    = eff_data[4*i +: 4];
        cur_dp     = eff_dp[i];
        cur_blank  = eff_blank[i];
        cur_blink  = eff_blink[i];
        cur_sup    = suppress[i];
      end
    end
    lit = (slot_cnt >= SW'(BLANK_CYC)) && (slot_cnt[3:0] <= bright) &&
          !cur_blank && !(cur_blink && blink_off) && !cur_sup;
    pattern  = {~cur_dp, font(cur_nib)};
    next_seg = SEG_OFF;
    next_sel = SEL_OFF;
    if (lit) begin
      next_seg = SEG_ACT_LOW ? pattern : ~pattern;
      next_sel = one_hot ^ SEL_OFF;
    end
  end

  // Output registers; reset drives them dark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SEG_S <= SEL_OFF;
      SEG   <= SEG_OFF;
    end else begin
      SEG_S <= next_sel;
      SEG   <= next_seg;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 64-clock slots, 4 dead cycles,
// blink half-period of 2 frames). Position c is the scan cycle counted from
// reset release. The output sampled on the falling edge after tick c+1 is the
// output for counter state c.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h1234;
  logic [3:0]  dp = 4'b0000;
  logic [3:0]  blank = 4'b0000;
  logic [3:0]  blink = 4'b0000;
  logic        lz_en = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [3:0]  seg_s;
  logic [7:0]  seg;

  int total = 0;
  int bad = 0;
  int t = 0;

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(64), .BLANK_CYC(4), .BLINK_FRAMES(2),
    .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .blink(blink),
    .lz_en(lz_en), .bright(bright), .SEG_S(seg_s), .SEG(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (c=%0d)", tag, got, exp, t - 1);
    end
  endtask

  // Advance to the falling edge where the output for scan cycle c is visible.
  task automatic goto(input int c);
    while (t < c + 1) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Check select and segment outputs at scan cycle c.
  task automatic expect_at(input string tag, input int c, input logic [3:0] s, input logic [7:0] g);
    goto(c);
    check({tag, ".sel"}, 32'(seg_s), 32'(s));
    check({tag, ".seg"}, 32'(seg), 32'(g));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.sel", 32'(seg_s), 32'h0);
    check("rst.seg", 32'(seg), 32'hFF);
    rst = 1'b0;
    t = 0;

    // Basic scan with data 1234: digit0 '4', digit1 '3', digit2 '2', digit3 '1'.
    expect_at("dead3",  3,   4'b0000, 8'hFF);
    expect_at("d0.c4",  4,   4'b0001, 8'h99);
    expect_at("d0.end", 63,  4'b0001, 8'h99);
    expect_at("d1.dead", 64, 4'b0000, 8'hFF);
    expect_at("d1",     68,  4'b0010, 8'hB0);
    expect_at("d2",     132, 4'b0100, 8'hA4);
    expect_at("d3",     196, 4'b1000, 8'hF9);
    expect_at("wrap",   260, 4'b0001, 8'h99);

    // Brightness sampled live: bright=3 lights slot_cnt[3:0] in 0..3 only.
    bright = 4'd3;
    expect_at("b3.s14", 270, 4'b0000, 8'hFF);
    expect_at("b3.s16", 272, 4'b0001, 8'h99);
    expect_at("b3.s19", 275, 4'b0001, 8'h99);
    expect_at("b3.s20", 276, 4'b0000, 8'hFF);
    bright = 4'd0;
    expect_at("b0.s32", 288, 4'b0001, 8'h99);
    expect_at("b0.s33", 289, 4'b0000, 8'hFF);
    bright = 4'hF;

    // Mid-frame data change (during digit-2 slot) waits for the next frame.
    goto(400);
    data = 16'h2222;
    expect_at("old.d2", 420, 4'b0100, 8'hA4);
    expect_at("old.d3", 452, 4'b1000, 8'hF9);
    expect_at("new.d0", 516, 4'b0001, 8'hA4);
    expect_at("new.d3", 708, 4'b1000, 8'hA4);

    // Blink on digit 1: phase off in frames 2-3 and 6-7, visible in 4-5.
    blink = 4'b0010;
    expect_at("bk.f3d0", 772,  4'b0001, 8'hA4);
    expect_at("bk.f3d1", 836,  4'b0000, 8'hFF);
    expect_at("bk.f4d1", 1092, 4'b0010, 8'hA4);
    expect_at("bk.f6d1", 1604, 4'b0000, 8'hFF);

    // Leading-zero suppression on 0050 (captured in frame 7).
    data = 16'h0050;
    blink = 4'b0000;
    lz_en = 1'b1;
    expect_at("lz.d0", 1796, 4'b0001, 8'hC0);
    expect_at("lz.d1", 1860, 4'b0010, 8'h92);
    expect_at("lz.d2", 1924, 4'b0000, 8'hFF);
    expect_at("lz.d3", 1988, 4'b0000, 8'hFF);
    lz_en = 1'b0;
    expect_at("nolz.d3", 2244, 4'b1000, 8'hC0);

    // A decimal point stops suppression at its digit (frame 9).
    lz_en = 1'b1;
    dp = 4'b0100;
    expect_at("dp.d2", 2436, 4'b0100, 8'h40);
    expect_at("dp.d3", 2500, 4'b0000, 8'hFF);

    // Blank digit 0 (frame 10).
    blank = 4'b0001;
    expect_at("bl.d0", 2564, 4'b0000, 8'hFF);
    expect_at("bl.d1", 2628, 4'b0010, 8'h92);

    // Asynchronous reset during a lit cycle.
    expect_at("pre.rst", 2630, 4'b0010, 8'h92);
    #2 rst = 1'b1;
    #1;
    check("arst.sel", 32'(seg_s), 32'h0);
    check("arst.seg", 32'(seg), 32'hFF);
    blank = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t = 0;
    expect_at("rs.dead3", 3, 4'b0000, 8'hFF);
    expect_at("rs.d0",    4, 4'b0001, 8'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
